jk_strobe_gen: RTL and testbench

//  Programmable count-and-compare sequencer that drives the J/K inputs of a downstream JK flip-flop cell.
//  - Counts enabled CK edges from 0 to TOP, then wraps.
//  - Emits one-cycle J (set) and K (clear) strobes at programmable counts, plus a terminal-count pulse.
//  - Keeps a shadow LVL equal to the Q of a JK flop fed by J/K with a matching clear.
//  - Used upstream of sync/blank/IRQ flops in the video and timer paths.

---
 rtl/jk_strobe_gen.sv | 119 +++++++++++
 tb/tb_jk_strobe_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_strobe_gen.sv
// Count-and-compare sequencer producing registered J/K/TC strobes for a downstream
// JK flop, plus a shadow LVL that tracks that flop's Q.
module jk_strobe_gen #(
  parameter int W = 8
) (
  input  logic         CK,
  input  logic         CL,
  input  logic         EN,
  input  logic         START,
  input  logic         STOP,
  input  logic         ONESHOT,
  input  logic [W-1:0] TOP,
  input  logic [W-1:0] SET_AT,
  input  logic [W-1:0] CLR_AT,
  output logic [W-1:0] CNT,
  output logic         J,
  output logic         K,
  output logic         TC,
  output logic         BUSY,
  output logic         LVL
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    DONE    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         j_q, j_d;
  logic         k_q, k_d;
  logic         tc_q, tc_d;
  logic         lvl_q, lvl_d;
  logic         os_q, os_d;
  logic         at_top;

  assign at_top = (cnt_q == TOP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    tc_d    = 1'b0;
    os_d    = os_q;

    if (STOP) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (START) begin
      state_d = RUN;
      cnt_d   = '0;
      os_d    = ONESHOT;
    end else begin
      case (state_q)
        RUN: begin
          if (EN) begin
            j_d   = (cnt_q == SET_AT);
            k_d   = (cnt_q == CLR_AT);
            tc_d  = at_top;
            // TOP lowered below CNT: no match until the natural 2^W wrap
            cnt_d = at_top ? '0 : cnt_q + W'(1);
            if (os_q && at_top) begin
              state_d = DONE;
            end
          end
        end
        IDLE, DONE: begin
          cnt_d = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Shadow JK flop fed by the registered strobes
  always_comb begin
    lvl_d = lvl_q;
    case ({j_q, k_q})
      2'b01:   lvl_d = 1'b0;
      2'b10:   lvl_d = 1'b1;
      2'b11:   lvl_d = ~lvl_q;
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge CK or posedge CL) begin
    if (CL) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      tc_q    <= 1'b0;
      lvl_q   <= 1'b0;
      os_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      tc_q    <= tc_d;
      lvl_q   <= lvl_d;
      os_q    <= os_d;
    end
  end

  assign CNT  = cnt_q;
  assign J    = j_q;
  assign K    = k_q;
  assign TC   = tc_q;
  assign LVL  = lvl_q;
  assign BUSY = (state_q == RUN);

endmodule

// File: tb/tb_jk_strobe_gen.sv
// Scoreboard bench for jk_strobe_gen: a behavioural model pushes expected outputs
// per clock edge, a monitor pops and compares them after each edge.
module tb_jk_strobe_gen;

  logic       CK = 1'b0;
  logic       CL = 1'b1;
  logic       EN = 1'b0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       ONESHOT = 1'b0;
  logic [7:0] TOP = 8'd0;
  logic [7:0] SET_AT = 8'd0;
  logic [7:0] CLR_AT = 8'd0;
  logic [7:0] CNT;
  logic       J, K, TC, BUSY, LVL;

  jk_strobe_gen #(.W(8)) dut (
    .CK(CK), .CL(CL), .EN(EN), .START(START), .STOP(STOP), .ONESHOT(ONESHOT),
    .TOP(TOP), .SET_AT(SET_AT), .CLR_AT(CLR_AT),
    .CNT(CNT), .J(J), .K(K), .TC(TC), .BUSY(BUSY), .LVL(LVL)
  );

  always #5 CK = ~CK;

  typedef struct {
    int cnt;
    bit j, k, tc, busy, lvl;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = finished single period
  int m_mode = 0;
  int m_cnt  = 0;
  bit m_j = 0, m_k = 0, m_tc = 0, m_lvl = 0, m_single = 0;

  always @(posedge CK or posedge CL) begin
    if (CL) begin
      m_mode = 0; m_cnt = 0; m_j = 0; m_k = 0; m_tc = 0; m_lvl = 0; m_single = 0;
    end else begin
      exp_t e;
      bit nj, nk, ntc;
      if (m_j && m_k) m_lvl = !m_lvl;
      else if (m_j)   m_lvl = 1;
      else if (m_k)   m_lvl = 0;
      nj = 0; nk = 0; ntc = 0;
      if (STOP) begin
        m_mode = 0; m_cnt = 0;
      end else if (START) begin
        m_mode = 1; m_cnt = 0; m_single = ONESHOT;
      end else if (m_mode == 1) begin
        if (EN) begin
          nj  = (m_cnt == int'(SET_AT));
          nk  = (m_cnt == int'(CLR_AT));
          ntc = (m_cnt == int'(TOP));
          if (ntc) begin
            m_cnt = 0;
            if (m_single) m_mode = 2;
          end else begin
            m_cnt = (m_cnt + 1) % 256;
          end
        end
      end else begin
        m_mode = 0 + m_mode; m_cnt = 0;
      end
      m_j = nj; m_k = nk; m_tc = ntc;
      e.cnt = m_cnt; e.j = m_j; e.k = m_k; e.tc = m_tc;
      e.busy = (m_mode == 1); e.lvl = m_lvl;
      exp_q.push_back(e);
    end
  end

  initial begin
    forever begin
      @(posedge CK);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if (int'(CNT) == e.cnt && J == e.j && K == e.k && TC == e.tc &&
            BUSY == e.busy && LVL == e.lvl) begin
          n_pass++;
        end else begin
          $display("FAIL scoreboard t=%0t got cnt=%0d j=%b k=%b tc=%b busy=%b lvl=%b exp cnt=%0d j=%b k=%b tc=%b busy=%b lvl=%b",
                   $time, CNT, J, K, TC, BUSY, LVL, e.cnt, e.j, e.k, e.tc, e.busy, e.lvl);
        end
      end
    end
  end

  task automatic check_cleared(input string name);
    n_checks++;
    if (CNT == 8'd0 && !J && !K && !TC && !BUSY && !LVL) begin
      n_pass++;
    end else begin
      $display("FAIL %s got cnt=%0d j=%b k=%b tc=%b busy=%b lvl=%b exp all zero",
               name, CNT, J, K, TC, BUSY, LVL);
    end
  endtask

  task automatic drive(input bit en, input bit st, input bit sp, input bit os, input int n);
    repeat (n) begin
      @(negedge CK);
      EN = en; START = st; STOP = sp; ONESHOT = os;
    end
  endtask

  task automatic cfg(input int top, input int set_at, input int clr_at);
    @(negedge CK);
    EN = 0; START = 0; STOP = 0;
    TOP = 8'(top); SET_AT = 8'(set_at); CLR_AT = 8'(clr_at);
  endtask

  // Asynchronous clear between clock edges, checked before the next edge
  task automatic async_clear(input string name);
    @(negedge CK);
    #1 CL = 1'b1;
    #1 check_cleared(name);
    #1 CL = 1'b0;
  endtask

  initial begin
    #23;
    check_cleared("power_on_reset");
    @(negedge CK);
    CL = 1'b0;

    // Clear mid-run at CNT=5
    cfg(9, 2, 7);
    drive(1, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 5);
    async_clear("clear_mid_run");

    // Free-running period of 10 with J at 2, K at 7
    cfg(9, 2, 7);
    drive(1, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 25);

    // Single period, TOP=3
    cfg(3, 1, 2);
    drive(1, 1, 0, 1, 1);
    drive(1, 0, 0, 0, 10);

    // J and K coincide: LVL toggles once per period
    cfg(7, 4, 4);
    drive(1, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 26);

    // Enable gap around the J compare
    cfg(9, 2, 9);
    drive(1, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 3);
    drive(0, 0, 0, 0, 3);
    drive(1, 0, 0, 0, 5);

    // START+STOP together at CNT=6, then TOP=0
    cfg(9, 1, 3);
    drive(1, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 6);
    drive(1, 1, 1, 0, 1);
    drive(1, 0, 0, 0, 3);
    cfg(0, 0, 5);
    drive(1, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 4);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 3);

    // Compares beyond TOP never fire; TOP lowered below CNT wraps through 255
    cfg(20, 30, 40);
    drive(1, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 15);
    @(negedge CK);
    TOP = 8'd4;
    drive(1, 0, 0, 0, 250);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge CK);
      STOP    = ($urandom % 40) == 0;
      START   = ($urandom % 25) == 0;
      EN      = ($urandom % 5) != 0;
      ONESHOT = ($urandom % 3) == 0;
      if (($urandom % 60) == 0) begin
        TOP    = 8'($urandom % 16);
        SET_AT = 8'($urandom % (int'(TOP) + 3));
        CLR_AT = 8'($urandom % (int'(TOP) + 3));
      end
      if (($urandom % 700) == 0) TOP = 8'($urandom % 256);
      if (($urandom % 600) == 0) begin
        #1 CL = 1'b1;
        #1 check_cleared("random_clear");
        #1 CL = 1'b0;
      end
    end

    drive(0, 0, 0, 0, 3);
    @(negedge CK);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
